// File: rtl/clk_period_monitor.sv
// clk_period_monitor
// Brings a slow divided clock into the clk_in domain, emits single-cycle
// rise/fall ticks, measures every rise-to-rise period in clk_in cycles,
// reports lock while the period stays inside the tolerance window and
// raises a sticky timeout when the slow clock stops toggling.
module clk_period_monitor #(
    parameter int EXP_HALF = 100000,
    parameter int TOL      = 64,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 18
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    // Window limits; comparisons use one extra bit so cnt+1 never wraps.
    localparam int LIM    = 2 * EXP_HALF + TOL;
    localparam int LOW    = 2 * EXP_HALF - TOL;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W:0]    LIM_X  = (CNT_W + 1)'(LIM);
    localparam logic [CNT_W:0]    LOW_X  = (CNT_W + 1)'(LOW);
    localparam logic [GOOD_W-1:0] LOCK_G = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_t;

    // Synchroniser and edge detector state.
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic rise_tick_q, rise_tick_d;
    logic fall_tick_q, fall_tick_d;

    // Measurement and lock tracking state.
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              period_valid_q, period_valid_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;

    logic              rise_ev;
    logic              fall_ev;
    logic [CNT_W:0]    cnt_inc;
    logic [GOOD_W-1:0] good_inc;
    logic              in_tol;

    // Next-state logic: synchroniser shift, edge ticks, period counter and FSM.
    always_comb begin
        rise_ev  = s2_q & ~s3_q;
        fall_ev  = ~s2_q & s3_q;
        cnt_inc  = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        good_inc = good_q + GOOD_W'(1);
        in_tol   = (cnt_inc >= LOW_X) && (cnt_inc <= LIM_X);

        s1_d           = slow_in;
        s2_d           = s1_q;
        s3_d           = s2_q;
        rise_tick_d    = rise_ev;
        fall_tick_d    = fall_ev;
        good_d         = good_q;
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        locked_d       = locked_q;
        timeout_d      = timeout_q;

        // Counter restarts on every rise and otherwise saturates at LIM.
        if (rise_ev) begin
            cnt_d = '0;
        end else if (cnt_inc >= LIM_X) begin
            cnt_d = LIM_X[CNT_W-1:0];
        end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end

        // A rise always takes priority over the timeout check on the same edge.
        if (rise_ev) begin
            case (state_q)
                IDLE: begin
                    // First rise only opens the measurement; nothing to capture yet.
                    state_d   = ACQ;
                    timeout_d = 1'b0;
                    good_d    = '0;
                end
                ACQ: begin
                    period_d       = cnt_inc[CNT_W-1:0];
                    period_valid_d = 1'b1;
                    if (in_tol) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_G) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCK: begin
                    period_d = cnt_inc[CNT_W-1:0];
                    if (!in_tol) begin
                        state_d  = ACQ;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if ((state_q != IDLE) && (cnt_inc == LIM_X)) begin
            // Slow clock has stopped: drop back to IDLE, keep the last period.
            timeout_d      = 1'b1;
            locked_d       = 1'b0;
            period_valid_d = 1'b0;
            good_d         = '0;
            state_d        = IDLE;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            rise_tick_q    <= 1'b0;
            fall_tick_q    <= 1'b0;
            cnt_q          <= '0;
            good_q         <= '0;
            state_q        <= IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            rise_tick_q    <= rise_tick_d;
            fall_tick_q    <= fall_tick_d;
            cnt_q          <= cnt_d;
            good_q         <= good_d;
            state_q        <= state_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign rise_tick    = rise_tick_q;
    assign fall_tick    = fall_tick_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor with a small window
// (EXP_HALF=10, TOL=2 -> accepted periods 18..22, LIM=22, LOCK_CNT=3).
module tb_clk_period_monitor;

    localparam int CNT_W = 6;

    localparam logic [1:0] K_RISE = 2'd0;
    localparam logic [1:0] K_FALL = 2'd1;
    localparam logic [1:0] K_TMO  = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [CNT_W-1:0] per;
        logic             pv;
        logic             lk;
        logic             tmo;
    } exp_t;

    logic             clk_in  = 1'b0;
    logic             reset   = 1'b0;
    logic             slow_in = 1'b0;
    logic             rise_tick;
    logic             fall_tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] mon_kind;
    logic       mon_ev;
    logic       tmo_prev = 1'b0;
    int         checks   = 0;
    int         errors   = 0;

    clk_period_monitor #(
        .EXP_HALF(10),
        .TOL     (2),
        .LOCK_CNT(3),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .slow_in     (slow_in),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached with %0d expected events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, int'({rise_tick, fall_tick, period, period_valid, locked, timeout}), 0);
    endtask

    task automatic push(input logic [1:0] k, input int per, input logic pv,
                        input logic lk, input logic tmo);
        exp_t e;
        e.kind = k;
        e.per  = CNT_W'(per);
        e.pv   = pv;
        e.lk   = lk;
        e.tmo  = tmo;
        exp_q.push_back(e);
    endtask

    // One slow_in period: hi cycles high, lo cycles low. The rise checks the
    // period measured from the previous raise; the fall sees the same state.
    task automatic cycle(input int hi, input int lo, input int per, input logic pv,
                         input logic lk, input logic tmo_after);
        slow_in = 1'b1;
        push(K_RISE, per, pv, lk, 1'b0);
        repeat (hi) @(negedge clk_in);
        slow_in = 1'b0;
        push(K_FALL, per, pv, lk, 1'b0);
        if (tmo_after) push(K_TMO, per, 1'b0, 1'b0, 1'b1);
        repeat (lo) @(negedge clk_in);
    endtask

    // Tick must be high only in the cycle between E2 and E3.
    task automatic lat_check(input string name, input logic use_fall);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("%s_E%0d", name, i), int'(use_fall ? fall_tick : rise_tick),
                  (i == 2) ? 1 : 0);
        end
    endtask

    // Monitor: classify each output event and compare against the scoreboard.
    always @(negedge clk_in) begin
        mon_ev   = 1'b1;
        mon_kind = K_RISE;
        if (rise_tick)                 mon_kind = K_RISE;
        else if (fall_tick)            mon_kind = K_FALL;
        else if (timeout && !tmo_prev) mon_kind = K_TMO;
        else                           mon_ev   = 1'b0;
        tmo_prev = timeout;
        if (mon_ev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event kind=%0d period=%0d required none", mon_kind, period);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mon_kind, period, period_valid, locked, timeout} != mon_e) begin
                    errors++;
                    $display("FAIL event actual kind=%0d per=%0d pv=%0b lk=%0b tmo=%0b required kind=%0d per=%0d pv=%0b lk=%0b tmo=%0b",
                             mon_kind, period, period_valid, locked, timeout,
                             mon_e.kind, mon_e.per, mon_e.pv, mon_e.lk, mon_e.tmo);
                end
            end
        end
    end

    initial begin
        // Reset held while slow_in toggles: everything stays at zero.
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            slow_in = ~slow_in;
            @(negedge clk_in);
            check_zero($sformatf("reset_hold_%0d", i));
        end
        reset = 1'b1;
        repeat (2) @(negedge clk_in);

        // Tick latency for both edges.
        slow_in = 1'b1;
        push(K_RISE, 0, 1'b0, 1'b0, 1'b0);
        lat_check("rise_lat", 1'b0);
        @(negedge clk_in);
        slow_in = 1'b0;
        push(K_FALL, 0, 1'b0, 1'b0, 1'b0);
        lat_check("fall_lat", 1'b1);
        @(negedge clk_in);
        reset = 1'b0;
        #1;
        check_zero("reset_pulse");
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);

        // Lock acquisition on a 20-cycle square wave.
        cycle(10, 10,  0, 1'b0, 1'b0, 1'b0);
        cycle(10, 10, 20, 1'b1, 1'b0, 1'b0);
        cycle(10, 10, 20, 1'b1, 1'b0, 1'b0);
        cycle(10,  8, 20, 1'b1, 1'b1, 1'b0);
        // Tolerance edges while locked: 18 and 22 keep lock, 17 drops it.
        cycle(10, 12, 18, 1'b1, 1'b1, 1'b0);
        cycle(10,  7, 22, 1'b1, 1'b1, 1'b0);
        cycle(10, 10, 17, 1'b1, 1'b0, 1'b0);
        cycle(10, 10, 20, 1'b1, 1'b0, 1'b0);
        cycle(10, 10, 20, 1'b1, 1'b0, 1'b0);
        // Relock, then slow_in stops low and times out.
        cycle(10, 30, 20, 1'b1, 1'b1, 1'b1);
        check("tmo_sticky", int'({timeout, locked, period_valid, period}), (4 << CNT_W) + 20);

        // Recovery: first rise only clears timeout, the next one captures 19.
        cycle(10,  9, 20, 1'b0, 1'b0, 1'b0);
        cycle(10, 12, 19, 1'b1, 1'b0, 1'b0);
        // Exactly LIM from ACQ: the rise wins over the timeout.
        cycle(10, 10, 22, 1'b1, 1'b0, 1'b0);
        cycle(10, 10, 20, 1'b1, 1'b1, 1'b0);

        // Reset mid-lock while a rise tick is pending.
        slow_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #2;
        check("pre_reset", int'({rise_tick, locked, period}), (3 << CNT_W) + 20);
        reset = 1'b0;
        #1;
        check_zero("reset_mid_lock");
        repeat (2) @(negedge clk_in);
        // slow_in already high at release: first rise fires but captures nothing.
        push(K_RISE, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (10) @(negedge clk_in);
        slow_in = 1'b0;
        push(K_FALL, 0, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk_in);
        cycle(10, 30, 20, 1'b1, 1'b0, 1'b1);

        repeat (3) @(negedge clk_in);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor.md
Name: clk_period_monitor

Overview:
- Receives a slow divided clock (e.g. a 500 Hz output of a clock divider) in the fast `clk_in` domain.
- Synchronises it and produces single-cycle rise and fall ticks for logic that runs on `clk_in`.
- Measures every rise-to-rise period in `clk_in` cycles and reports lock when the period stays within tolerance of the nominal value.
- Flags a timeout when the slow clock stops.

Parameters:
- EXP_HALF, 100000, nominal half-period of `slow_in` in `clk_in` cycles; nominal full period = 2*EXP_HALF.
- TOL, 64, accepted deviation of the full period in cycles, applied symmetrically.
- LOCK_CNT, 4, number of consecutive in-tolerance periods required to lock.
- CNT_W, 18, counter and period width; must satisfy 2^CNT_W > 2*EXP_HALF+TOL.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state clears immediately while low.
- slow_in  in  1  asynchronous slow clock to monitor.
- rise_tick  out  1  one-cycle pulse per synchronised rising edge of `slow_in`.
- fall_tick  out  1  one-cycle pulse per synchronised falling edge of `slow_in`.
- period  out  CNT_W  last measured rise-to-rise period in `clk_in` cycles.
- period_valid  out  1  high once at least one period has been captured since reset or timeout.
- locked  out  1  high while the period is tracking within tolerance.
- timeout  out  1  sticky level: no rise seen within the limit; cleared by the next rise event.

Behaviour:
- Reset (reset=0): sync flops s1/s2/s3=0, cnt=0, good=0, state=IDLE; all outputs 0 (period=0).
- Synchroniser: s1<=slow_in, s2<=s1, s3<=s2.
  - rise_ev = s2 & ~s3; fall_ev = ~s2 & s3.
  - rise_tick<=rise_ev and fall_tick<=fall_ev, both registered.
  - Latency: a `slow_in` transition that meets setup before edge E0 makes the tick high for exactly the cycle between E2 and E3.
  - If `slow_in` is already 1 at reset release, the first rise event fires normally.
- Counter: on a rise_ev edge, cnt<=0; otherwise cnt<=cnt+1, saturating at LIM=2*EXP_HALF+TOL.
  - The measured period at a rise_ev edge is cnt+1.
  - Capturable range is 1..LIM.
- In-tolerance test: 2*EXP_HALF-TOL <= cnt+1 <= LIM.
- States: IDLE, ACQ, LOCK.
  - IDLE, rise_ev → ACQ; no period captured; timeout<=0; good<=0.
  - ACQ, rise_ev:
    - period<=cnt+1, period_valid<=1.
    - In tolerance: good<=good+1; if good+1==LOCK_CNT → LOCK, locked<=1 on the same edge.
    - Out of tolerance: good<=0, stay ACQ.
  - LOCK, rise_ev:
    - period<=cnt+1.
    - In tolerance: stay LOCK.
    - Out of tolerance: → ACQ, locked<=0 on the same edge, good<=0.
  - Any state except IDLE, no rise_ev and cnt+1==LIM:
    - cnt<=LIM, timeout<=1, locked<=0, period_valid<=0, good<=0, state<=IDLE.
    - period holds its last value.
  - In IDLE with cnt already at LIM: cnt stays saturated and timeout stays 1.
- Simultaneous events:
  - rise_ev always wins over timeout on the same edge, so a period of exactly LIM is captured and accepted.
  - rise_ev and fall_ev are mutually exclusive by construction.
- Reset asserted mid-operation forces the reset values asynchronously, regardless of state or pending ticks.
- fall_tick is independent of the FSM and is produced in every state.

Test Plan:
Bench parameters: EXP_HALF=10, TOL=2, LOCK_CNT=3, CNT_W=6. This gives window 18..22 and LIM=22.
1. Reset/latency: hold reset=0 while toggling `slow_in` → all outputs 0. Release, then raise `slow_in` mid-cycle before E0 → rise_tick=1 only between E2 and E3. Lower it → fall_tick behaves identically.
2. Lock acquisition: square wave, 10 cycles high / 10 low.
   - First rise: no period, period_valid=0.
   - Rises 2..4: period=20 each.
   - locked=1 on the edge of the 4th rise event.
3. Tolerance edges while locked: periods 18 and 22 → locked stays 1 and period shows 18 and 22. Period 17 → period=17, locked=0 on that rise edge. Three periods of 20 follow → locked=1 again.
4. Timeout: stop `slow_in` low after a locked rise.
   - On the edge where cnt reaches 22: timeout=1, locked=0, period_valid=0, period holds 20.
   - Next rise → timeout=0, period unchanged.
   - The following rise captures a new period.
5. Reset mid-lock: pull reset low asynchronously mid-cycle → locked, period, timeout and ticks go to 0 immediately. After release, the first rise captures nothing.
6. Simultaneity: apply a period of exactly 22 from ACQ → the rise wins, period=22, good increments, timeout stays 0.
